// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: one full round key per cycle over a valid/ready handshake.
// Optional AES_KEY_SCHED_STORE_EN adds an 11-entry round-key store with a registered read port.
module aes128_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
`ifdef AES_KEY_SCHED_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  generate
    if (NR < 1 || NR > 10) begin : g_bad_nr
      $error("aes128_key_sched: NR must be in 1..10");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t      state;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, rot, t;
  logic [31:0] n0, n1, n2, n3;
  logic        xfer;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] a, b, p;
    a = x;
    b = y;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign w0  = rk_out[127:96];
  assign w1  = rk_out[95:64];
  assign w2  = rk_out[63:32];
  assign w3  = rk_out[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h000000};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign xfer = (state == EMIT) && rk_valid && rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_round <= '0;
      rcon     <= 8'h01;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk_out   <= key_in;
            rk_round <= '0;
            rcon     <= 8'h01;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (rk_round == LAST) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              rk_out   <= {n0, n1, n2, n3};
              rk_round <= rk_round + 4'd1;
              rcon     <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_SCHED_STORE_EN
  logic [127:0] store [0:10];

  always_ff @(posedge clk) begin
    if (xfer) store[rk_round] <= rk_out;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_key <= '0;
    else if (rd_idx > LAST) rd_key <= '0;
    else rd_key <= store[rd_idx];
  end
`endif

endmodule

// File: doc/aes128_key_sched.md
Name: aes128_key_sched

Overview:
- Iterative AES-128 key-expansion stage that sits directly upstream of the AES round unit.
- Accepts a 128-bit cipher key and emits round keys 0..NR, one per valid/ready transfer, in the same word packing the round unit consumes: bits [127:96] = word0, down to bits [31:0] = word3.
- Computes one full round key (4 words) per cycle with no bubbles under continuous ready.

Parameters:
- NR, 10, index of the last round key emitted. Legal range 1..10; an out-of-range value is a compile-time error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request expansion of key_in; sampled only in IDLE
- key_in  in  128  cipher key; [127:96] = w0
- busy  out  1  high from the cycle after start is accepted until the cycle after the last transfer
- rk_valid  out  1  rk_out/rk_round hold a valid round key
- rk_ready  in  1  downstream accepts the current round key
- rk_out  out  128  current round key, packed like key_in
- rk_round  out  4  index of rk_out, 0..NR
- done  out  1  one-cycle pulse after round NR is transferred

Behaviour:
- Reset values: busy=0, rk_valid=0, rk_out=0, rk_round=0, done=0, rcon register=8'h01, state=IDLE.
- States: IDLE, EMIT.
- IDLE:
  - start=1 latches key_in into rk_out and sets rk_round=0, rcon=8'h01, rk_valid=1, busy=1; state moves to EMIT.
  - Latency from start to first rk_valid is 1 cycle.
- EMIT:
  - Transfer occurs when rk_valid && rk_ready.
  - Transfer with rk_round<NR: the next cycle has rk_out = next round key, rk_round+1, rcon = xtime(rcon), rk_valid still 1 (zero-bubble).
  - Transfer with rk_round==NR: next cycle has rk_valid=0, busy=0, done=1 for exactly one cycle; state returns to IDLE. rk_out and rk_round keep their last values.
  - rk_valid && !rk_ready: rk_out, rk_round and rcon hold stable. rk_valid never drops without a transfer.
- Next-key arithmetic (FIPS-197):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - RotWord rotates left by one byte.
  - SubWord applies the AES S-box per byte, computed combinationally inside the block (GF(2^8) inverse + affine). No external memory is used.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- Boundary rules:
  - start while busy is ignored, including in the same cycle as the final transfer. key_in is not re-sampled.
  - start in the cycle done=1 is accepted (state is IDLE).
  - rst asserted mid-expansion returns all outputs to reset values on the next edge. No done pulse is generated.
  - NR=1: emits keys 0 and 1 only.

Optional Feature:
- Macro: AES_KEY_SCHED_STORE_EN
- Enabled:
  - Every transferred round key is written into an internal 11x128 register file at index rk_round.
  - Adds ports rd_idx in 4 and rd_key out 128.
  - rd_key = stored key at rd_idx, registered, 1-cycle read latency. Reset value 0.
  - rd_idx>NR returns 0.
  - A new start does not clear the store; entries are overwritten as keys are re-emitted.
  - Purpose: reverse-order key replay for decryption.
- Disabled: no storage and no extra ports; the block's other behaviour is identical.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready held 1:
  - rk_round 0 carries the key.
  - rk_round 1 = a0fafe1788542cb123a339392a6c7605.
  - rk_round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles, done pulses on the cycle after round 10.
- Same key with rk_ready toggled randomly: the identical 11-key sequence appears; rk_out is stable whenever valid && !ready; no key is dropped or duplicated.
- start pulsed at round 4 with key 000...0: ignored; sequence continues for the original key. A second start on the done cycle is accepted, and rk_round 1 = 62636363626363636263636362636363.
- rst asserted at round 6: next cycle busy=0, rk_valid=0, rk_out=0, no done pulse. A following start restarts at round 0.
- NR=1 build with the FIPS-197 key: exactly two transfers (round 0, then round 1 = a0fafe17…2a6c7605), then done.
- With AES_KEY_SCHED_STORE_EN, after the FIPS-197 expansion completes: rd_idx=10 returns d014f9a8…b6630ca6 one cycle later; rd_idx=0 returns the cipher key; rd_idx=12 returns 0.
